// File: rtl/fractal_sync_req_initiator.sv
// Fractal sync request initiator (leaf side).
// Takes one barrier request from the local requester, issues it toward the
// first fractal sync node, waits for the matching wake-up response and then
// reports completion or an error code back to the requester.
// Optional feature macro: FRACTAL_SYNC_TIMEOUT_EN. When it is defined, a wait
// that lasts TIMEOUT_CYCLES cycles is aborted with error code 3. The default
// build (macro undefined) has no counter, and WAIT has no time limit.

package fractal_sync_pkg;

    // Width of the source/destination code carried with every barrier
    localparam int SD_WIDTH = 2;

    // Error codes reported on sync_err_o together with sync_done_o
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_BAD_ID  = 2'd1;
    localparam logic [1:0] ERR_NETWORK = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

module fractal_sync_req_initiator #(
    parameter int ID_WIDTH       = 2,
    parameter int MAX_LOCAL_ID   = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int SD_WIDTH      = fractal_sync_pkg::SD_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                sync_req_i,
    input  logic [ID_WIDTH-1:0] sync_id_i,
    input  logic [SD_WIDTH-1:0] sync_sd_i,
    output logic                sync_gnt_o,
    output logic                sync_busy_o,
    output logic                sync_done_o,
    output logic [1:0]          sync_err_o,

    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic [ID_WIDTH-1:0] req_id_o,
    output logic [SD_WIDTH-1:0] req_sd_o,

    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    input  logic [ID_WIDTH-1:0] rsp_id_i,
    input  logic [SD_WIDTH-1:0] rsp_sd_i,
    input  logic                rsp_err_i,
    output logic                stray_o
);

    import fractal_sync_pkg::*;

    // A zero or negative timeout would make the expiry compare meaningless
    generate
        if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
            $error("fractal_sync_req_initiator: TIMEOUT_CYCLES must be > 0");
        end
    endgenerate

    // Largest legal local id, widened so it can be compared with any id width
    localparam logic [31:0] MAX_ID = MAX_LOCAL_ID;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [SD_WIDTH-1:0]   sd_q;
    logic [1:0]            err_q;

    logic [31:0]           req_local_id;
    logic                  bad_id;
    logic                  rsp_fire;
    logic                  rsp_match;

`ifdef FRACTAL_SYNC_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  cnt_expired;

    assign cnt_expired = (cnt_q == CNT_LAST);
`endif

    // Bit 0 of the id is the direction/level flag; only the upper bits form the
    // local id that the first node's register file can hold.
    assign req_local_id = 32'(sync_id_i[ID_WIDTH-1:1]);
    assign bad_id       = (req_local_id > MAX_ID);

    // A response is consumed in every WAIT cycle it is offered; it only ends
    // the barrier when both the id and the SD code agree with the latched pair.
    assign rsp_fire  = (state_q == WAIT) && rsp_valid_i;
    assign rsp_match = (rsp_id_i == id_q) && (rsp_sd_i == sd_q);

    // Barrier sequencing: latch the request, push it to the node, wait for the
    // wake-up and report the result for one cycle. Reset drops any barrier in
    // flight without reporting it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            sd_q    <= '0;
            err_q   <= ERR_OK;
`ifdef FRACTAL_SYNC_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (sync_req_i) begin
                        id_q <= sync_id_i;
                        sd_q <= sync_sd_i;
                        if (bad_id) begin
                            err_q   <= ERR_BAD_ID;
                            state_q <= RESP;
                        end else begin
                            err_q   <= ERR_OK;
                            state_q <= SEND;
                        end
                    end
                end

                SEND: begin
                    if (req_ready_i) begin
                        state_q <= WAIT;
`ifdef FRACTAL_SYNC_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end

                WAIT: begin
                    if (rsp_fire && rsp_match) begin
                        err_q   <= rsp_err_i ? ERR_NETWORK : ERR_OK;
                        state_q <= RESP;
                    end
`ifdef FRACTAL_SYNC_TIMEOUT_EN
                    else if (cnt_expired) begin
                        err_q   <= ERR_TIMEOUT;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
`endif
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Grant is a same-cycle acknowledge of the level request seen in IDLE; it is
    // held low while reset is applied so every output reads 0 during reset.
    assign sync_gnt_o  = (state_q == IDLE) && sync_req_i && !rst_i;
    assign sync_busy_o = (state_q != IDLE);
    assign sync_done_o = (state_q == RESP);
    assign sync_err_o  = (state_q == RESP) ? err_q : ERR_OK;

    assign req_valid_o = (state_q == SEND);
    assign req_id_o    = id_q;
    assign req_sd_o    = sd_q;

    assign rsp_ready_o = (state_q == WAIT);
    assign stray_o     = rsp_fire && !rsp_match;

endmodule

// File: tb/tb_fractal_sync_req_initiator.sv
// Directed bench for fractal_sync_req_initiator.
// Each cycle the full output status is packed into one vector and compared
// against a hand-derived constant; latched id/SD are checked separately.
// Status bits: [7] gnt [6] busy [5] done [4:3] err [2] req_valid
//              [1] rsp_ready [0] stray

module tb_fractal_sync_req_initiator;

    localparam int ID_WIDTH = 2;
    localparam int SD_WIDTH = fractal_sync_pkg::SD_WIDTH;

    localparam logic [7:0] ST_IDLE  = 8'h00;
    localparam logic [7:0] ST_GNT   = 8'h80;
    localparam logic [7:0] ST_SEND  = 8'h44;
    localparam logic [7:0] ST_WAIT  = 8'h42;
    localparam logic [7:0] ST_STRAY = 8'h43;
    localparam logic [7:0] ST_DONE0 = 8'h60;
    localparam logic [7:0] ST_DONE1 = 8'h68;
    localparam logic [7:0] ST_DONE2 = 8'h70;
    localparam logic [7:0] ST_DONE3 = 8'h78;

    logic                clk_i;
    logic                rst_i;
    logic                sync_req_i;
    logic [ID_WIDTH-1:0] sync_id_i;
    logic [SD_WIDTH-1:0] sync_sd_i;
    logic                sync_gnt_o;
    logic                sync_busy_o;
    logic                sync_done_o;
    logic [1:0]          sync_err_o;
    logic                req_valid_o;
    logic                req_ready_i;
    logic [ID_WIDTH-1:0] req_id_o;
    logic [SD_WIDTH-1:0] req_sd_o;
    logic                rsp_valid_i;
    logic                rsp_ready_o;
    logic [ID_WIDTH-1:0] rsp_id_i;
    logic [SD_WIDTH-1:0] rsp_sd_i;
    logic                rsp_err_i;
    logic                stray_o;

    logic [7:0]          status_vec;

    int checks = 0;
    int errors = 0;

    fractal_sync_req_initiator #(
        .ID_WIDTH       (ID_WIDTH),
        .MAX_LOCAL_ID   (0),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sync_req_i  (sync_req_i),
        .sync_id_i   (sync_id_i),
        .sync_sd_i   (sync_sd_i),
        .sync_gnt_o  (sync_gnt_o),
        .sync_busy_o (sync_busy_o),
        .sync_done_o (sync_done_o),
        .sync_err_o  (sync_err_o),
        .req_valid_o (req_valid_o),
        .req_ready_i (req_ready_i),
        .req_id_o    (req_id_o),
        .req_sd_o    (req_sd_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_id_i    (rsp_id_i),
        .rsp_sd_i    (rsp_sd_i),
        .rsp_err_i   (rsp_err_i),
        .stray_o     (stray_o)
    );

    assign status_vec = {sync_gnt_o, sync_busy_o, sync_done_o, sync_err_o,
                         req_valid_o, rsp_ready_o, stray_o};

    // Free-running 10 ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check the status on the falling edge, then move to just after the next
    // rising edge where the following cycle's inputs are driven.
    task automatic check_cycle(input string tag, input logic [7:0] expected);
        @(negedge clk_i);
        check_output(tag, 32'(status_vec), 32'(expected));
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_latch(input string tag, input logic [ID_WIDTH-1:0] id,
                               input logic [SD_WIDTH-1:0] sd);
        check_output({tag, "_id"}, 32'(req_id_o), 32'(id));
        check_output({tag, "_sd"}, 32'(req_sd_o), 32'(sd));
    endtask

    task automatic apply_req(input logic req, input logic [ID_WIDTH-1:0] id,
                             input logic [SD_WIDTH-1:0] sd);
        sync_req_i = req;
        sync_id_i  = id;
        sync_sd_i  = sd;
    endtask

    task automatic apply_rsp(input logic valid, input logic [ID_WIDTH-1:0] id,
                             input logic [SD_WIDTH-1:0] sd, input logic err);
        rsp_valid_i = valid;
        rsp_id_i    = id;
        rsp_sd_i    = sd;
        rsp_err_i   = err;
    endtask

    // Linear sequence of directed scenarios
    initial begin
        rst_i       = 1'b1;
        req_ready_i = 1'b0;
        apply_req(1'b0, 2'b00, 2'd0);
        apply_rsp(1'b0, 2'b00, 2'd0, 1'b0);
        @(posedge clk_i);
        #1;

        // Reset state
        check_cycle("reset_status", ST_IDLE);
        check_latch("reset", 2'b00, 2'd0);
        rst_i = 1'b0;
        check_cycle("idle_after_reset", ST_IDLE);

        // Nominal barrier: gnt@0, req_valid@1, rsp@4, done@5
        req_ready_i = 1'b1;
        apply_req(1'b1, 2'b01, 2'd1);
        check_cycle("nom_gnt", ST_GNT);
        sync_req_i = 1'b0;
        check_latch("nom_latch", 2'b01, 2'd1);
        check_cycle("nom_send", ST_SEND);
        check_cycle("nom_wait0", ST_WAIT);
        check_cycle("nom_wait1", ST_WAIT);
        apply_rsp(1'b1, 2'b01, 2'd1, 1'b0);
        check_cycle("nom_rsp", ST_WAIT);
        apply_rsp(1'b0, 2'b00, 2'd0, 1'b0);
        check_cycle("nom_done", ST_DONE0);

        // Response offered in IDLE is neither accepted nor stray
        apply_rsp(1'b1, 2'b01, 2'd1, 1'b0);
        check_cycle("idle_rsp_ignored", ST_IDLE);
        apply_rsp(1'b0, 2'b00, 2'd0, 1'b0);
        check_latch("idle_latch_kept", 2'b01, 2'd1);

        // Backpressure: node holds ready low for 4 cycles
        req_ready_i = 1'b0;
        apply_req(1'b1, 2'b01, 2'd2);
        check_cycle("bp_gnt", ST_GNT);
        sync_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_latch("bp_stall", 2'b01, 2'd2);
            check_cycle("bp_send_stall", ST_SEND);
        end
        req_ready_i = 1'b1;
        check_cycle("bp_send_hs", ST_SEND);
        req_ready_i = 1'b0;
        check_cycle("bp_wait", ST_WAIT);
        apply_rsp(1'b1, 2'b01, 2'd2, 1'b0);
        check_cycle("bp_rsp", ST_WAIT);
        apply_rsp(1'b0, 2'b00, 2'd0, 1'b0);
        check_cycle("bp_done", ST_DONE0);
        check_cycle("bp_idle", ST_IDLE);

        // Bad local id: done with err 1 one cycle after gnt, no request issued
        req_ready_i = 1'b1;
        apply_req(1'b1, 2'b11, 2'd1);
        check_cycle("bad_gnt", ST_GNT);
        sync_req_i = 1'b0;
        check_latch("bad_latch", 2'b11, 2'd1);
        check_cycle("bad_done", ST_DONE1);
        check_cycle("bad_idle", ST_IDLE);

        // Stray (wrong id) then match; next request held through RESP
        apply_req(1'b1, 2'b01, 2'd3);
        check_cycle("st_gnt", ST_GNT);
        sync_req_i = 1'b0;
        check_cycle("st_send", ST_SEND);
        apply_rsp(1'b1, 2'b00, 2'd3, 1'b0);
        check_cycle("st_stray", ST_STRAY);
        apply_rsp(1'b1, 2'b01, 2'd3, 1'b0);
        check_cycle("st_match", ST_WAIT);
        apply_rsp(1'b0, 2'b00, 2'd0, 1'b0);
        apply_req(1'b1, 2'b01, 2'd0);
        check_cycle("st_done_no_gnt", ST_DONE0);
        check_cycle("st_regnt", ST_GNT);
        sync_req_i = 1'b0;
        check_latch("st2_latch", 2'b01, 2'd0);

        // Stray (wrong SD) then match carrying a network error
        check_cycle("st2_send", ST_SEND);
        apply_rsp(1'b1, 2'b01, 2'd3, 1'b0);
        check_cycle("st2_stray", ST_STRAY);
        apply_rsp(1'b1, 2'b01, 2'd0, 1'b1);
        check_cycle("st2_match", ST_WAIT);
        apply_rsp(1'b0, 2'b00, 2'd0, 1'b0);
        check_cycle("st2_done", ST_DONE2);
        check_cycle("st2_idle", ST_IDLE);

        // Reset while waiting: outputs clear at once, no done pulse
        apply_req(1'b1, 2'b01, 2'd1);
        check_cycle("rst_gnt", ST_GNT);
        sync_req_i = 1'b0;
        check_cycle("rst_send", ST_SEND);
        check_cycle("rst_wait", ST_WAIT);
        rst_i = 1'b1;
        check_cycle("rst_mid", ST_IDLE);
        check_latch("rst_mid", 2'b00, 2'd0);
        rst_i = 1'b0;
        check_cycle("rst_no_done", ST_IDLE);
        apply_req(1'b1, 2'b01, 2'd1);
        check_cycle("rst_regnt", ST_GNT);
        sync_req_i = 1'b0;
        check_cycle("rst_resend", ST_SEND);
        check_cycle("rst_rewait", ST_WAIT);
        apply_rsp(1'b1, 2'b01, 2'd1, 1'b0);
        check_cycle("rst_rsp", ST_WAIT);
        apply_rsp(1'b0, 2'b00, 2'd0, 1'b0);
        check_cycle("rst_done", ST_DONE0);
        check_cycle("rst_idle", ST_IDLE);

`ifdef FRACTAL_SYNC_TIMEOUT_EN
        // Timeout: 8 WAIT cycles with no response, then done with err 3
        apply_req(1'b1, 2'b01, 2'd1);
        check_cycle("to_gnt", ST_GNT);
        sync_req_i = 1'b0;
        check_cycle("to_send", ST_SEND);
        for (int i = 0; i < 8; i++) begin
            check_cycle("to_wait", ST_WAIT);
        end
        check_cycle("to_done", ST_DONE3);
        check_cycle("to_idle", ST_IDLE);

        // Match on the expiry cycle wins over the timeout
        apply_req(1'b1, 2'b01, 2'd1);
        check_cycle("race_gnt", ST_GNT);
        sync_req_i = 1'b0;
        check_cycle("race_send", ST_SEND);
        for (int i = 0; i < 7; i++) begin
            check_cycle("race_wait", ST_WAIT);
        end
        apply_rsp(1'b1, 2'b01, 2'd1, 1'b0);
        check_cycle("race_rsp", ST_WAIT);
        apply_rsp(1'b0, 2'b00, 2'd0, 1'b0);
        check_cycle("race_done", ST_DONE0);
        check_cycle("race_idle", ST_IDLE);
`else
        // Without the timeout the wait outlasts TIMEOUT_CYCLES untouched
        apply_req(1'b1, 2'b01, 2'd1);
        check_cycle("long_gnt", ST_GNT);
        sync_req_i = 1'b0;
        check_cycle("long_send", ST_SEND);
        for (int i = 0; i < 12; i++) begin
            check_cycle("long_wait", ST_WAIT);
        end
        apply_rsp(1'b1, 2'b01, 2'd1, 1'b0);
        check_cycle("long_rsp", ST_WAIT);
        apply_rsp(1'b0, 2'b00, 2'd0, 1'b0);
        check_cycle("long_done", ST_DONE0);
        check_cycle("long_idle", ST_IDLE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
